fip_32_cramer_div: RTL and testbench

//  Sequential Q(32-FRA_BITS).FRA_BITS divider that consumes the determinant stream of the 3x3 det stage.

---
 rtl/fip_pkg.sv | 32 +++
 rtl/fip_32_div_seq.sv | 82 ++++++++
 rtl/fip_32_cramer_div.sv | 195 +++++++++++++++++++
 tb/tb_fip_32_cramer_div.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fip_pkg.sv
// Shared fixed-point definitions for the fip_32 datapath blocks.
//   FIP_MIN/FIP_MAX : extreme values of a signed 32-bit fixed-point word
//   TRUE/FALSE      : single-bit flag constants
//   FRA_BITS_DFLT   : default number of fractional bits
//   cdiv_state_t    : control states of the Cramer divider
//   fip_abs33       : magnitude of a signed 32-bit word, widened so FIP_MIN is exact
package fip_pkg;

  localparam logic signed [31:0] FIP_MIN       = 32'sh8000_0000;
  localparam logic signed [31:0] FIP_MAX       = 32'sh7FFF_FFFF;
  localparam logic               TRUE          = 1'b1;
  localparam logic               FALSE         = 1'b0;
  localparam int                 FRA_BITS_DFLT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } cdiv_state_t;

  // |x| on 33 bits: -FIP_MIN = 2^31 does not fit in 32 signed bits.
  function automatic logic [32:0] fip_abs33(input logic signed [31:0] x);
    logic [32:0] r;
    if (x[31]) begin
      r = 33'd0 - {x[31], x};
    end else begin
      r = {1'b0, x};
    end
    return r;
  endfunction

endpackage

// File: rtl/fip_32_div_seq.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
//   i_clk, i_rstn   : clock, synchronous active-low reset
//   i_start         : load i_dividend/i_divisor (has priority over a running divide)
//   i_dividend      : DW-bit dividend
//   i_divisor       : VW-bit divisor (non-zero)
//   o_quot          : quotient as it will be after the current iteration
//   o_done          : the current cycle performs the last iteration; o_quot is final
// The quotient is exposed one step early so the caller can capture it and
// restart the core on the same edge, leaving no idle cycle between divides.
module fip_32_div_seq #(
  parameter int DW = 48,
  parameter int VW = 33
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic [DW-1:0] o_quot,
  output logic          o_done
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0] quot_r;
  logic [VW-1:0] rem_r;
  logic [VW-1:0] div_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;

  logic [VW:0]   rem_sh_s;
  logic          ge_s;
  logic [VW-1:0] diff_s;
  logic [VW-1:0] rem_nxt_s;
  logic [DW-1:0] quot_nxt_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder stays below the divisor, so a restored value always fits VW bits.
  always_comb begin
    rem_sh_s   = {rem_r, quot_r[DW-1]};
    ge_s       = (rem_sh_s >= {1'b0, div_r});
    diff_s     = VW'(rem_sh_s - {1'b0, div_r});
    if (ge_s) begin
      rem_nxt_s = diff_s;
    end else begin
      rem_nxt_s = rem_sh_s[VW-1:0];
    end
    quot_nxt_s = {quot_r[DW-2:0], ge_s};
  end

  assign o_quot = quot_nxt_s;
  assign o_done = busy_r && (cnt_r == CW'(DW - 1));

  // Operand load and iteration registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      quot_r <= {DW{1'b0}};
      rem_r  <= {VW{1'b0}};
      div_r  <= {VW{1'b0}};
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
    end else if (i_start) begin
      quot_r <= i_dividend;
      rem_r  <= {VW{1'b0}};
      div_r  <= i_divisor;
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b1;
    end else if (busy_r) begin
      quot_r <= quot_nxt_s;
      rem_r  <= rem_nxt_s;
      cnt_r  <= cnt_r + CW'(1);
      busy_r <= (cnt_r != CW'(DW - 1));
    end else begin
      quot_r <= quot_r;
      rem_r  <= rem_r;
      div_r  <= div_r;
      cnt_r  <= cnt_r;
      busy_r <= busy_r;
    end
  end

endmodule

// File: rtl/fip_32_cramer_div.sv
// Cramer's-rule solver back end: quot[k] = num[k] / det for k = 0..2, signed
// Q(32-FRA_BITS).FRA_BITS, truncated toward zero, saturated to the 32-bit range.
// One shared sequential divider handles the three numerators in index order.
//   i_clk, i_rstn : clock, synchronous active-low reset
//   i_valid/o_ready, i_det, i_num[3]      : input transaction
//   o_valid/i_ready, o_quot[3], o_sat[3], o_singular : result (held until accepted)
// det == 0 skips the divider: result is all-zero quotients with o_singular set.
module fip_32_cramer_div
  import fip_pkg::*;
#(
  parameter int FRA_BITS = FRA_BITS_DFLT,
  parameter int N_QUOT   = 3
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic signed [31:0] i_det,
  input  logic signed [31:0] i_num [N_QUOT],
  output logic               o_valid,
  input  logic               i_ready,
  output logic signed [31:0] o_quot [N_QUOT],
  output logic [N_QUOT-1:0]  o_sat,
  output logic               o_singular
);

  localparam int         DW       = 32 + FRA_BITS;
  localparam logic [1:0] LAST_IDX = 2'(N_QUOT - 1);

  cdiv_state_t        state_r;
  cdiv_state_t        state_s;
  logic [1:0]         idx_r;
  logic signed [31:0] det_r;
  logic signed [31:0] num_r [N_QUOT];
  logic signed [31:0] res_r [N_QUOT-1];
  logic [N_QUOT-2:0]  sat_r;

  logic [1:0]         op_idx_s;
  logic signed [31:0] op_num_s;
  logic [32:0]        op_det_abs_s;
  logic [32:0]        op_num_abs_s;
  logic [DW-1:0]      dividend_s;
  logic               start_s;
  logic [DW-1:0]      core_quot_s;
  logic               core_done_s;
  logic               neg_s;
  logic [32:0]        cnv_s;

  // {sat, value}: apply the sign to an unsigned quotient magnitude and clamp.
  function automatic logic [32:0] sat_quot(input logic neg, input logic [DW-1:0] mag);
    logic [32:0] r;
    if (!neg && (mag > {{(DW-32){1'b0}}, FIP_MAX})) begin
      r = {1'b1, FIP_MAX};
    end else if (neg && (mag > {{(DW-32){1'b0}}, FIP_MIN})) begin
      r = {1'b1, FIP_MIN};
    end else if (neg) begin
      r = {1'b0, 32'd0 - mag[31:0]};
    end else begin
      r = {1'b0, mag[31:0]};
    end
    return r;
  endfunction

  // Divider operand selection: straight from the inputs on the accept edge,
  // otherwise the next captured numerator when the current divide finishes.
  always_comb begin
    op_idx_s = (idx_r == LAST_IDX) ? 2'd0 : idx_r + 2'd1;
    if (state_r == IDLE) begin
      op_num_s     = i_num[0];
      op_det_abs_s = fip_abs33(i_det);
      start_s      = i_valid && (i_det != 32'sd0);
    end else begin
      op_num_s     = num_r[op_idx_s];
      op_det_abs_s = fip_abs33(det_r);
      start_s      = (state_r == DIV) && core_done_s && (idx_r != LAST_IDX);
    end
    op_num_abs_s = fip_abs33(op_num_s);
    dividend_s   = DW'(op_num_abs_s) << FRA_BITS;
  end

  fip_32_div_seq #(
    .DW (DW),
    .VW (33)
  ) u_div (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_start    (start_s),
    .i_dividend (dividend_s),
    .i_divisor  (op_det_abs_s),
    .o_quot     (core_quot_s),
    .o_done     (core_done_s)
  );

  // Signed, saturated form of the quotient finishing this cycle.
  always_comb begin
    neg_s = num_r[idx_r][31] ^ det_r[31];
    cnv_s = sat_quot(neg_s, core_quot_s);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_valid) begin
          state_s = (i_det == 32'sd0) ? DONE : DIV;
        end else begin
          state_s = IDLE;
        end
      end
      DIV: begin
        if (core_done_s && (idx_r == LAST_IDX)) begin
          state_s = DONE;
        end else begin
          state_s = DIV;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand capture, partial results and registered outputs.
  // o_quot/o_sat only change when DONE is entered, so they stay stable while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r    <= IDLE;
      idx_r      <= 2'd0;
      det_r      <= 32'sd0;
      num_r      <= '{default: 32'sd0};
      res_r      <= '{default: 32'sd0};
      sat_r      <= {(N_QUOT-1){1'b0}};
      o_ready    <= TRUE;
      o_valid    <= FALSE;
      o_quot     <= '{default: 32'sd0};
      o_sat      <= {N_QUOT{1'b0}};
      o_singular <= FALSE;
    end else begin
      state_r <= state_s;
      o_ready <= (state_s == IDLE);
      o_valid <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            det_r <= i_det;
            num_r <= i_num;
            idx_r <= 2'd0;
            if (i_det == 32'sd0) begin
              o_quot     <= '{default: 32'sd0};
              o_sat      <= {N_QUOT{1'b0}};
              o_singular <= TRUE;
            end
          end
        end
        DIV: begin
          if (core_done_s) begin
            case (idx_r)
              2'd0: begin
                res_r[0] <= cnv_s[31:0];
                sat_r[0] <= cnv_s[32];
                idx_r    <= 2'd1;
              end
              2'd1: begin
                res_r[1] <= cnv_s[31:0];
                sat_r[1] <= cnv_s[32];
                idx_r    <= 2'd2;
              end
              default: begin
                o_quot     <= '{res_r[0], res_r[1], cnv_s[31:0]};
                o_sat      <= {cnv_s[32], sat_r};
                o_singular <= FALSE;
                idx_r      <= 2'd0;
              end
            endcase
          end
        end
        DONE: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fip_32_cramer_div.sv
module tb_fip_32_cramer_div;
  import fip_pkg::*;

  typedef struct packed {
    logic [2:0][31:0] q;
    logic [2:0]       sat;
    logic             sing;
  } exp_t;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               i_valid = 1'b0;
  logic               i_ready = 1'b1;
  logic               o_ready;
  logic               o_valid;
  logic               o_singular;
  logic signed [31:0] i_det = 32'sd0;
  logic signed [31:0] i_num [3];
  logic signed [31:0] o_quot [3];
  logic [2:0]         o_sat;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fip_32_cramer_div dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_det      (i_det),
    .i_num      (i_num),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_quot     (o_quot),
    .o_sat      (o_sat),
    .o_singular (o_singular)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: ((num << 16) / det) in 64-bit signed arithmetic, truncating, then clamped.
  function automatic exp_t model(input logic [31:0] det, input logic [2:0][31:0] num);
    exp_t   e;
    longint n;
    longint d;
    longint q;
    e = '0;
    e.sing = (det == 32'h0);
    for (int k = 0; k < 3; k++) begin
      if (!e.sing) begin
        n = longint'($signed(num[k])) * 64'sd65536;
        d = longint'($signed(det));
        q = n / d;
        if (q > 64'sd2147483647) begin
          e.q[k] = 32'h7FFF_FFFF; e.sat[k] = 1'b1;
        end else if (q < -64'sd2147483648) begin
          e.q[k] = 32'h8000_0000; e.sat[k] = 1'b1;
        end else begin
          e.q[k] = q[31:0];
        end
      end
    end
    return e;
  endfunction

  task automatic drive_txn(input logic [31:0] det, input logic [2:0][31:0] num);
    int w;
    w = 0;
    while (o_ready !== 1'b1 && w < 400) begin tick(); w++; end
    check("ready_before_accept", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_det   = det;
    for (int k = 0; k < 3; k++) i_num[k] = num[k];
    sb.push_back(model(det, num));
    tick();  // accept edge
    i_valid = 1'b0;
    i_det   = $urandom;
    for (int k = 0; k < 3; k++) i_num[k] = $urandom;
    check("ready_low_after_accept", {31'd0, o_ready}, 32'd0);
  endtask

  // Latency counts edges after the accept edge; a singular transaction reaches
  // DONE on the accept edge itself, so its latency is 0.
  task automatic wait_result(input int exp_lat, input int stall);
    int   edges;
    exp_t e;
    edges = 0;
    while (o_valid !== 1'b1 && edges < 400) begin tick(); edges++; end
    check("latency", edges, exp_lat);
    check("o_valid_done", {31'd0, o_valid}, 32'd1);
    check("o_ready_done", {31'd0, o_ready}, 32'd0);
    check("scoreboard_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        tick();
        check("stall_valid", {31'd0, o_valid}, 32'd1);
        check("stall_ready", {31'd0, o_ready}, 32'd0);
      end
      check("quot0", o_quot[0], e.q[0]);
      check("quot1", o_quot[1], e.q[1]);
      check("quot2", o_quot[2], e.q[2]);
      check("sat", {29'd0, o_sat}, {29'd0, e.sat});
      check("singular", {31'd0, o_singular}, {31'd0, e.sing});
    end
    i_ready = 1'b1;
    tick();  // result handshake edge
    check("valid_after_hs", {31'd0, o_valid}, 32'd0);
    check("ready_after_hs", {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    logic [2:0][31:0] nv;
    logic [31:0]      dv;
    bit               saw;

    for (int k = 0; k < 3; k++) i_num[k] = 32'sd0;
    rstn = 1'b0;
    repeat (3) tick();
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_singular", {31'd0, o_singular}, 32'd0);
    check("rst_sat", {29'd0, o_sat}, 32'd0);
    check("rst_quot0", o_quot[0], 32'd0);
    check("rst_quot1", o_quot[1], 32'd0);
    check("rst_quot2", o_quot[2], 32'd0);
    rstn = 1'b1;
    tick();

    // 1.0/2, -3.0/2, 0.5/2
    nv[0] = 32'h0001_0000; nv[1] = 32'hFFFD_0000; nv[2] = 32'h0000_8000;
    drive_txn(32'h0002_0000, nv);
    wait_result(144, 0);

    // 1.0 / -3.0 truncates toward zero
    nv[0] = 32'h0001_0000; nv[1] = 32'h0005_4321; nv[2] = 32'hFFF0_0001;
    drive_txn(32'hFFFD_0000, nv);
    wait_result(144, 0);

    // Saturation both ways, zero numerator
    nv[0] = 32'h7FFF_0000; nv[1] = 32'h8000_0000; nv[2] = 32'h0000_0000;
    drive_txn(32'h0000_0100, nv);
    wait_result(144, 0);

    // Singular
    nv[0] = 32'h1234_5678; nv[1] = 32'h8000_0000; nv[2] = 32'hFFFF_FFFF;
    drive_txn(32'h0000_0000, nv);
    wait_result(0, 0);

    // FIP_MIN operands: MIN/MIN = 1.0, MIN/-1.0 overflows, MIN/-MIN limit
    nv[0] = FIP_MIN; nv[1] = 32'h0000_0001; nv[2] = 32'hFFFF_FFFF;
    drive_txn(FIP_MIN, nv);
    wait_result(144, 0);
    nv[0] = FIP_MIN; nv[1] = 32'h0000_0001; nv[2] = 32'h7FFF_FFFF;
    drive_txn(32'hFFFF_0000, nv);
    wait_result(144, 0);

    // Random operands of varied magnitude
    for (int r = 0; r < 3; r++) begin
      dv = $urandom >> $urandom_range(4, 20);
      for (int k = 0; k < 3; k++) nv[k] = $urandom >> $urandom_range(0, 16);
      if ($urandom_range(0, 1) == 1) dv = 32'd0 - dv;
      drive_txn(dv, nv);
      wait_result((dv == 32'd0) ? 0 : 144, 0);
    end

    // Downstream stall with the next transaction already waiting
    nv[0] = 32'h0003_0000; nv[1] = 32'hFFFF_8000; nv[2] = 32'h0100_0000;
    drive_txn(32'h0000_C000, nv);
    i_ready = 1'b0;
    nv[0] = 32'h0000_4000; nv[1] = 32'h0002_0000; nv[2] = 32'hFFFE_0000;
    i_valid = 1'b1;
    i_det   = 32'hFFFF_8000;
    for (int k = 0; k < 3; k++) i_num[k] = nv[k];
    sb.push_back(model(32'hFFFF_8000, nv));
    wait_result(144, 10);
    tick();  // accept edge after one IDLE cycle
    check("accept_after_idle", {31'd0, o_ready}, 32'd0);
    i_valid = 1'b0;
    wait_result(144, 0);

    // Reset in the middle of a divide aborts it
    nv[0] = 32'h0007_0000; nv[1] = 32'h0001_0000; nv[2] = 32'hFFF9_0000;
    drive_txn(32'h0001_8000, nv);
    repeat (60) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("abort_ready", {31'd0, o_ready}, 32'd1);
    check("abort_valid", {31'd0, o_valid}, 32'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    saw = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (o_valid === 1'b1) saw = 1'b1;
    end
    check("no_valid_after_abort", {31'd0, saw}, 32'd0);
    nv[0] = 32'h0000_0001; nv[1] = 32'h0064_0000; nv[2] = 32'hFF9C_0000;
    drive_txn(32'h0000_0007, nv);
    wait_result(144, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
